gray_step_decoder: RTL and testbench

//   Downstream consumer of Gray-coded position words (e.g. bin2gray output or an

---
 rtl/gray_step_decoder.sv | 98 +++++++++
 tb/tb_gray_step_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gray_step_decoder.sv
// rtl/gray_step_decoder.sv - Gray sample decoder with step classification, position and error tracking
module gray_step_decoder #(
    parameter int WIDTH = 4,
    parameter int POS_W = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_err,
    output logic [POS_W-1:0] pos,
    output logic [ERR_W-1:0] err_count
);

    logic [WIDTH-1:0] gray_s1;
    logic             valid_s1;
    logic [WIDTH-1:0] prev_bin;
    logic             have_prev;

    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] diff;
    logic             is_up;
    logic             is_dn;
    logic             is_err;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Classification is only meaningful once a reference sample exists.
    always_comb begin
        new_bin = gray2bin(gray_s1);
        diff    = new_bin - prev_bin;
        is_up   = 1'b0;
        is_dn   = 1'b0;
        is_err  = 1'b0;
        if (valid_s1 && have_prev) begin
            if (diff == WIDTH'(1)) begin
                is_up = 1'b1;
            end else if (diff == {WIDTH{1'b1}}) begin
                is_dn = 1'b1;
            end else if (diff != '0) begin
                is_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_s1   <= '0;
            valid_s1  <= 1'b0;
            prev_bin  <= '0;
            have_prev <= 1'b0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            step_err  <= 1'b0;
            pos       <= '0;
            err_count <= '0;
        end else begin
            gray_s1   <= gray_in;
            valid_s1  <= gray_valid;
            bin_valid <= valid_s1;
            step_up   <= is_up;
            step_dn   <= is_dn;
            step_err  <= is_err;
            if (valid_s1) begin
                bin_out   <= new_bin;
                prev_bin  <= new_bin;
                have_prev <= 1'b1;
            end
            if (is_up) begin
                pos <= pos + POS_W'(1);
            end else if (is_dn) begin
                pos <= pos - POS_W'(1);
            end
            // Clear takes priority over a coincident error increment.
            if (clr_err) begin
                err_count <= '0;
            end else if (is_err && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gray_step_decoder.sv
// tb/tb_gray_step_decoder.sv - directed table-driven bench for gray_step_decoder
module tb_gray_step_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gray_in;
    logic       gray_valid;
    logic       clr_err;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_up;
    logic       step_dn;
    logic       step_err;
    logic [7:0] pos;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_step_decoder #(.WIDTH(4), .POS_W(8), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .gray_valid (gray_valid),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .step_err   (step_err),
        .pos        (pos),
        .err_count  (err_count)
    );

    typedef struct {
        logic [3:0] gray;
        logic       valid;
        logic       clr;
        logic       bv;
        logic [3:0] bin;
        logic [2:0] fl;
        logic [7:0] pos;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[$];

    // Tuple layout: {bin_valid, bin_out, step_up, step_dn, step_err, pos, err_count}
    logic [23:0] act;
    assign act = {bin_valid, bin_out, step_up, step_dn, step_err, pos, err_count};

    task automatic add(input logic [3:0] g, input logic v, input logic c, input logic bv,
                       input logic [3:0] b, input logic [2:0] fl, input logic [7:0] p,
                       input logic [7:0] e);
        vec_t r;
        r.gray = g; r.valid = v; r.clr = c; r.bv = bv;
        r.bin = b; r.fl = fl; r.pos = p; r.ec = e;
        vecs.push_back(r);
    endtask

    task automatic check(input string nm, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; gray_valid = 1'b0; clr_err = 1'b0; gray_in = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gray_in = 4'd0; gray_valid = 1'b0; clr_err = 1'b0;

        // flags: 3'b100 up, 3'b010 down, 3'b001 error
        add(4'b0101, 1, 0, 1, 4'd6,  3'b000, 8'd0,  8'd0);
        add(4'b0100, 1, 0, 1, 4'd7,  3'b100, 8'd1,  8'd0);
        add(4'b0101, 1, 0, 1, 4'd6,  3'b010, 8'd0,  8'd0);
        add(4'b0101, 1, 0, 1, 4'd6,  3'b000, 8'd0,  8'd0);
        add(4'b1000, 1, 0, 1, 4'd15, 3'b001, 8'd0,  8'd1);
        add(4'b0000, 1, 0, 1, 4'd0,  3'b100, 8'd1,  8'd1);
        add(4'b1000, 1, 0, 1, 4'd15, 3'b010, 8'd0,  8'd1);
        add(4'b0000, 1, 0, 1, 4'd0,  3'b100, 8'd1,  8'd1);
        add(4'b0110, 1, 0, 1, 4'd4,  3'b001, 8'd1,  8'd2);
        add(4'b0111, 1, 0, 1, 4'd5,  3'b100, 8'd2,  8'd2);
        add(4'b1010, 0, 0, 0, 4'd5,  3'b000, 8'd2,  8'd2);
        add(4'b0000, 1, 0, 1, 4'd0,  3'b001, 8'd2,  8'd3);
        add(4'b0001, 1, 0, 1, 4'd1,  3'b100, 8'd3,  8'd3);
        add(4'b0011, 1, 0, 1, 4'd2,  3'b100, 8'd4,  8'd3);
        add(4'b0010, 1, 0, 1, 4'd3,  3'b100, 8'd5,  8'd3);
        add(4'b0110, 1, 0, 1, 4'd4,  3'b100, 8'd6,  8'd3);
        add(4'b0111, 1, 0, 1, 4'd5,  3'b100, 8'd7,  8'd3);
        add(4'b0101, 1, 0, 1, 4'd6,  3'b100, 8'd8,  8'd3);
        add(4'b0100, 1, 0, 1, 4'd7,  3'b100, 8'd9,  8'd3);
        add(4'b1100, 1, 0, 1, 4'd8,  3'b100, 8'd10, 8'd3);
        add(4'b1010, 0, 0, 0, 4'd8,  3'b000, 8'd10, 8'd3);
        add(4'b1101, 1, 0, 1, 4'd9,  3'b100, 8'd11, 8'd3);
        add(4'b1010, 0, 0, 0, 4'd9,  3'b000, 8'd11, 8'd3);
        add(4'b1111, 1, 0, 1, 4'd10, 3'b100, 8'd12, 8'd3);
        add(4'b1010, 0, 0, 0, 4'd10, 3'b000, 8'd12, 8'd3);
        add(4'b1110, 1, 0, 1, 4'd11, 3'b100, 8'd13, 8'd3);
        add(4'b1010, 0, 0, 0, 4'd11, 3'b000, 8'd13, 8'd3);
        // clr on the next row lands on the edge that processes this error
        add(4'b0000, 1, 0, 1, 4'd0,  3'b001, 8'd13, 8'd0);
        add(4'b0000, 1, 1, 1, 4'd0,  3'b000, 8'd13, 8'd0);
        add(4'b0001, 1, 0, 1, 4'd1,  3'b100, 8'd14, 8'd0);
        add(4'b0110, 1, 0, 1, 4'd4,  3'b001, 8'd14, 8'd1);
        add(4'b0111, 1, 0, 1, 4'd5,  3'b100, 8'd15, 8'd1);

        do_reset();
        check("reset_state", 24'h0);

        for (int i = 0; i < vecs.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("row%0d", i - 2),
                      {vecs[i-2].bv, vecs[i-2].bin, vecs[i-2].fl, vecs[i-2].pos, vecs[i-2].ec});
            end
            if (i < vecs.size()) begin
                gray_in = vecs[i].gray; gray_valid = vecs[i].valid; clr_err = vecs[i].clr;
            end else begin
                gray_valid = 1'b0; clr_err = 1'b0;
            end
        end

        // Saturation: first sample then 299 alternating errors
        do_reset();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            gray_in = (k % 2 == 1) ? 4'b0110 : 4'b0000;
            gray_valid = 1'b1;
        end
        @(negedge clk);
        gray_valid = 1'b0;
        @(negedge clk);
        check("sat_reach", {1'b1, 4'd4, 3'b001, 8'd0, 8'd255});
        gray_in = 4'b0000; gray_valid = 1'b1;
        @(negedge clk);
        gray_valid = 1'b0;
        @(negedge clk);
        check("sat_hold", {1'b1, 4'd0, 3'b001, 8'd0, 8'd255});

        // Reset with a sample in flight: discarded, next sample treated as first
        gray_in = 4'b0001; gray_valid = 1'b1;
        @(negedge clk);
        gray_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("flush%0d", k), 24'h0);
            @(negedge clk);
        end
        gray_in = 4'b0001; gray_valid = 1'b1;
        @(negedge clk);
        gray_valid = 1'b0;
        @(negedge clk);
        check("first_after_rst", {1'b1, 4'd1, 3'b000, 8'd0, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
